// File: rtl/microwave_cook_ctrl.sv
// microwave_cook_ctrl: cook-cycle sequencer for the magnetron SR latch.
// Drives one-cycle set/reset pulses to the latch from start/stop/door,
// runs the seconds prescaler plus cook-time down-counter and the done beep.
// Optional feature macro: COOK_PAUSE_EN (door open / stop while cooking
// pauses and keeps the remaining time instead of aborting to IDLE).
module microwave_cook_ctrl #(
    parameter int TW          = 8,
    parameter int TICK_DIV    = 50000000,
    parameter int BEEP_CYCLES = 25000000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_door_closed,
    input  logic [TW-1:0] i_time_set,
    output logic          o_latch_s,
    output logic          o_latch_r,
    output logic          o_mag_on,
    output logic [TW-1:0] o_remaining,
    output logic          o_beep,
    output logic [1:0]    o_state
);

    // Prescaler holds 0..TICK_DIV-1, beep counter holds 0..BEEP_CYCLES-1.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LOAD  = BW'(BEEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COOKING = 2'd1,
        S_PAUSED  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [TW-1:0] r_remaining;
    logic [BW-1:0] r_beep_cnt;
    logic          r_latch_s;
    logic          r_latch_r;
    logic          r_mag_on;
    logic          r_beep;

    state_t        w_state;
    logic [PW-1:0] w_presc;
    logic [TW-1:0] w_remaining;
    logic [BW-1:0] w_beep_cnt;
    logic          w_latch_s;
    logic          w_latch_r;
    logic          w_mag_on;
    logic          w_beep;
    logic          w_abort;
    logic          w_tick;

    // Door open outranks stop, and both outrank the tick and start.
    assign w_abort = !i_door_closed || i_stop;
    assign w_tick  = (r_presc == PRESC_LAST);

    // Next-state and next-output logic; pulses default low so they last one cycle.
    always_comb begin
        w_state     = r_state;
        w_presc     = r_presc;
        w_remaining = r_remaining;
        w_beep_cnt  = r_beep_cnt;
        w_latch_s   = 1'b0;
        w_latch_r   = 1'b0;
        w_mag_on    = r_mag_on;
        w_beep      = r_beep;
        case (r_state)
            S_IDLE: begin
                if (!w_abort && i_start && (i_time_set != '0)) begin
                    w_state     = S_COOKING;
                    w_remaining = i_time_set;
                    w_presc     = '0;
                    w_latch_s   = 1'b1;
                    w_mag_on    = 1'b1;
                end
            end
            S_COOKING: begin
                if (w_abort) begin
                    w_latch_r = 1'b1;
                    w_mag_on  = 1'b0;
`ifdef COOK_PAUSE_EN
                    w_state   = S_PAUSED;
`else
                    w_state     = S_IDLE;
                    w_remaining = '0;
                    w_presc     = '0;
`endif
                end else if (w_tick) begin
                    w_presc = '0;
                    if (r_remaining <= TW'(1)) begin
                        w_remaining = '0;
                        w_state     = S_DONE;
                        w_latch_r   = 1'b1;
                        w_mag_on    = 1'b0;
                        w_beep      = 1'b1;
                        w_beep_cnt  = BEEP_LOAD;
                    end else begin
                        w_remaining = r_remaining - TW'(1);
                    end
                end else begin
                    w_presc = r_presc + PW'(1);
                end
            end
`ifdef COOK_PAUSE_EN
            S_PAUSED: begin
                if (i_stop) begin
                    w_state     = S_IDLE;
                    w_remaining = '0;
                    w_presc     = '0;
                end else if (i_start && i_door_closed) begin
                    w_state   = S_COOKING;
                    w_latch_s = 1'b1;
                    w_mag_on  = 1'b1;
                end
            end
`endif
            S_DONE: begin
                if (i_stop || (r_beep_cnt == '0)) begin
                    w_state = S_IDLE;
                    w_beep  = 1'b0;
                end else begin
                    w_beep_cnt = r_beep_cnt - BW'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces the magnetron latch off.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_remaining <= '0;
            r_beep_cnt  <= '0;
            r_latch_s   <= 1'b0;
            r_latch_r   <= 1'b1;
            r_mag_on    <= 1'b0;
            r_beep      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_presc     <= w_presc;
            r_remaining <= w_remaining;
            r_beep_cnt  <= w_beep_cnt;
            r_latch_s   <= w_latch_s;
            r_latch_r   <= w_latch_r;
            r_mag_on    <= w_mag_on;
            r_beep      <= w_beep;
        end
    end

    assign o_latch_s   = r_latch_s;
    assign o_latch_r   = r_latch_r;
    assign o_mag_on    = r_mag_on;
    assign o_remaining = r_remaining;
    assign o_beep      = r_beep;
    assign o_state     = r_state;

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// tb_microwave_cook_ctrl: directed vector table plus hand sequences for
// microwave_cook_ctrl with TICK_DIV=4, BEEP_CYCLES=3 (honours COOK_PAUSE_EN).
module tb_microwave_cook_ctrl;

    localparam int TW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop;
    logic          doorClosed;
    logic [TW-1:0] timeSet;
    logic          latchS;
    logic          latchR;
    logic          magOn;
    logic [TW-1:0] remaining;
    logic          beep;
    logic [1:0]    state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          rst;
        logic          start;
        logic          stop;
        logic          door;
        logic [TW-1:0] ts;
        logic          ls;
        logic          lr;
        logic          mag;
        logic [TW-1:0] rem;
        logic          bp;
        logic [1:0]    st;
    } vec_t;

    vec_t vecs[$];

    microwave_cook_ctrl #(
        .TW(TW),
        .TICK_DIV(4),
        .BEEP_CYCLES(3)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_stop(stop),
        .i_door_closed(doorClosed),
        .i_time_set(timeSet),
        .o_latch_s(latchS),
        .o_latch_r(latchR),
        .o_mag_on(magOn),
        .o_remaining(remaining),
        .o_beep(beep),
        .o_state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic r, input logic s, input logic p,
                                 input logic d, input logic [TW-1:0] t);
        @(negedge clk);
        rst        = r;
        start      = s;
        stop       = p;
        doorClosed = d;
        timeSet    = t;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ls, input logic lr,
                               input logic mag, input logic [TW-1:0] rem,
                               input logic bp, input logic [1:0] st);
        logic [TW+5:0] got;
        logic [TW+5:0] exp;
        got = {latchS, latchR, magOn, remaining, beep, state};
        exp = {ls, lr, mag, rem, bp, st};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got ls=%b lr=%b mag=%b rem=%0d beep=%b st=%0d, required ls=%b lr=%b mag=%b rem=%0d beep=%b st=%0d",
                     name, latchS, latchR, magOn, remaining, beep, state,
                     ls, lr, mag, rem, bp, st);
        end
    endtask

    task automatic addVec(input logic r, input logic s, input logic p, input logic d,
                          input logic [TW-1:0] t, input logic ls, input logic lr,
                          input logic mag, input logic [TW-1:0] rem, input logic bp,
                          input logic [1:0] st);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.door = d; v.ts = t;
        v.ls = ls; v.lr = lr; v.mag = mag; v.rem = rem; v.bp = bp; v.st = st;
        vecs.push_back(v);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        doorClosed = 1'b1;
        timeSet    = '0;

        //     rst st sp dr ts   ls lr mg rem bp st
        addVec(1, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        addVec(1, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        addVec(1, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0);
        addVec(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0);
        addVec(0, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0);
        addVec(0, 1, 0, 0, 2,   0, 0, 0, 0, 0, 0);
        addVec(0, 1, 1, 1, 2,   0, 0, 0, 0, 0, 0);
        addVec(0, 1, 0, 1, 2,   1, 0, 1, 2, 0, 1);
        addVec(0, 0, 0, 1, 2,   0, 0, 1, 2, 0, 1);
        addVec(0, 1, 0, 1, 2,   0, 0, 1, 2, 0, 1);
        addVec(0, 0, 0, 1, 2,   0, 0, 1, 2, 0, 1);
        addVec(0, 0, 0, 1, 2,   0, 0, 1, 1, 0, 1);
        addVec(0, 0, 0, 1, 2,   0, 0, 1, 1, 0, 1);
        addVec(0, 0, 0, 1, 2,   0, 0, 1, 1, 0, 1);
        addVec(0, 0, 0, 1, 2,   0, 0, 1, 1, 0, 1);
        addVec(0, 0, 0, 1, 2,   0, 1, 0, 0, 1, 3);
        addVec(0, 1, 0, 1, 2,   0, 0, 0, 0, 1, 3);
        addVec(0, 0, 0, 1, 2,   0, 0, 0, 0, 1, 3);
        addVec(0, 0, 0, 1, 2,   0, 0, 0, 0, 0, 0);
        addVec(0, 1, 0, 1, 3,   1, 0, 1, 3, 0, 1);
`ifdef COOK_PAUSE_EN
        addVec(0, 1, 1, 1, 3,   0, 1, 0, 3, 0, 2);
        addVec(0, 0, 0, 1, 3,   0, 0, 0, 3, 0, 2);
`else
        addVec(0, 1, 1, 1, 3,   0, 1, 0, 0, 0, 0);
        addVec(0, 0, 0, 1, 3,   0, 0, 0, 0, 0, 0);
`endif
        addVec(0, 0, 1, 1, 3,   0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].door, vecs[i].ts);
            checkOutput($sformatf("vec%0d", i), vecs[i].ls, vecs[i].lr, vecs[i].mag,
                        vecs[i].rem, vecs[i].bp, vecs[i].st);
        end

        // Door opened mid-cook: time 5, door opens after 6 cooking cycles.
        applyStimulus(0, 1, 0, 1, 5);
        checkOutput("door_start", 1, 0, 1, 5, 0, 1);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 0, 0, 1, 5);
            if (i == 4) checkOutput("door_first_dec", 0, 0, 1, 4, 0, 1);
        end
        applyStimulus(0, 0, 0, 0, 5);
`ifdef COOK_PAUSE_EN
        checkOutput("door_open", 0, 1, 0, 4, 0, 2);
        applyStimulus(0, 0, 0, 0, 5);
        checkOutput("door_hold", 0, 0, 0, 4, 0, 2);
        applyStimulus(0, 1, 0, 1, 5);
        checkOutput("door_resume", 1, 0, 1, 4, 0, 1);
        applyStimulus(0, 0, 0, 1, 5);
        checkOutput("resume_p3", 0, 0, 1, 4, 0, 1);
        applyStimulus(0, 0, 0, 1, 5);
        checkOutput("resume_dec", 0, 0, 1, 3, 0, 1);
`else
        checkOutput("door_open", 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 5);
        checkOutput("door_hold", 0, 0, 0, 0, 0, 0);
`endif

        // Reset from any state, then a reset while cooking.
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("rst_any", 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 9);
        checkOutput("rst_cook_start", 1, 0, 1, 9, 0, 1);
        applyStimulus(0, 0, 0, 1, 9);
        applyStimulus(1, 0, 0, 1, 9);
        checkOutput("rst_mid_cook", 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("rst_release", 0, 0, 0, 0, 0, 0);

        // Door opens on the same edge as the final tick: door wins, no beep.
        applyStimulus(0, 1, 0, 1, 1);
        checkOutput("final_start", 1, 0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1);
        checkOutput("final_pre", 0, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
`ifdef COOK_PAUSE_EN
        checkOutput("final_door", 0, 1, 0, 1, 0, 2);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("final_after", 0, 0, 0, 1, 0, 2);
`else
        checkOutput("final_door", 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("final_after", 0, 0, 0, 0, 0, 0);
`endif

        // Random traffic: the two latch pulses must never coincide.
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(($urandom_range(0, 499) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 19) != 0),
                          TW'($urandom_range(0, 3)));
            checks++;
            if (latchS && latchR) begin
                failures++;
                $display("[TB] FAIL latch_excl cycle %0d: got latch_s=%b latch_r=%b, required not both 1",
                         i, latchS, latchR);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
